// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encodings, default frame parameters and counter-width helper
package uart_pkg;

    localparam int UART_N_DATA_BITS = 8;
    localparam int UART_OVERSAMPLE  = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } uart_state_e;

    // Width of a counter that must hold 0..n-1, never narrower than one bit
    function automatic int uart_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for an asynchronous input that idles high
module uart_rx_sync (
    input  logic i_uart_clk,
    input  logic i_uart_reset,
    input  logic async_in,
    output logic sync_out
);

    logic meta;

    // Capture every clock; reset to the idle-high level so no false start is seen
    always_ff @(posedge i_uart_clk) begin
        if (!i_uart_reset) {sync_out, meta} <= 2'b11;
        else {sync_out, meta} <= {meta, async_in};
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with valid/ready output, framing-error and overrun pulses
module uart_rx
    import uart_pkg::*;
#(
    parameter int N_DATA_BITS = UART_N_DATA_BITS,
    parameter int OVERSAMPLE  = UART_OVERSAMPLE
) (
    input  logic                   i_uart_clk,
    input  logic                   i_uart_reset,
    input  logic                   i_uart_en,
    input  logic                   i_uart_rx,
    input  logic                   i_uart_ready,
    output logic [N_DATA_BITS-1:0] o_uart_data,
    output logic                   o_uart_data_valid,
    output logic                   o_uart_frame_err,
    output logic                   o_uart_overrun,
    output logic                   o_uart_busy
);

    localparam int TW = uart_cnt_w(OVERSAMPLE);
    localparam int BW = uart_cnt_w(N_DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(N_DATA_BITS - 1);

    logic                   rx_s;
    uart_state_e            state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [N_DATA_BITS-1:0] shreg_q, shreg_d;
    logic                   deliver;
    logic                   frame_err_d;
    logic                   load;

    uart_rx_sync u_sync (
        .i_uart_clk   (i_uart_clk),
        .i_uart_reset (i_uart_reset),
        .async_in     (i_uart_rx),
        .sync_out     (rx_s)
    );

    // Frame recovery: counters and samples advance only on oversample ticks
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
        if (i_uart_en) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end
                end
                ST_START: begin
                    if (tick_q == TICK_MID) begin
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                        tick_d  = '0;
                        bit_d   = '0;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        shreg_d[bit_q] = rx_s;
                        tick_d         = '0;
                        state_d        = (bit_q == BIT_LAST) ? ST_STOP : ST_DATA;
                        bit_d          = (bit_q == BIT_LAST) ? bit_q : bit_q + 1'b1;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d      = '0;
                        deliver     = rx_s;
                        frame_err_d = !rx_s;
                        state_d     = rx_s ? ST_IDLE : ST_BREAK;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (rx_s) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // A finished word may load when the buffer is empty or being drained on this edge
    assign load = deliver && (!o_uart_data_valid || i_uart_ready);

    // State register plus output buffer and handshake, updated every clock
    always_ff @(posedge i_uart_clk) begin
        if (!i_uart_reset) begin
            state_q           <= ST_IDLE;
            tick_q            <= '0;
            bit_q             <= '0;
            shreg_q           <= '0;
            o_uart_data       <= '0;
            o_uart_data_valid <= 1'b0;
            o_uart_frame_err  <= 1'b0;
            o_uart_overrun    <= 1'b0;
            o_uart_busy       <= 1'b0;
        end else begin
            state_q           <= state_d;
            tick_q            <= tick_d;
            bit_q             <= bit_d;
            shreg_q           <= shreg_d;
            o_uart_data       <= load ? shreg_q : o_uart_data;
            o_uart_data_valid <= load || (o_uart_data_valid && !i_uart_ready);
            o_uart_frame_err  <= frame_err_d;
            o_uart_overrun    <= deliver && !load;
            o_uart_busy       <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Oversampling UART receiver. It is the receive-side counterpart of uart_tx in the AES_UART datapath.
- Recovers 1 start bit, N_DATA_BITS data bits (LSB first) and 1 stop bit from the asynchronous serial line.
- Presents each received word on a valid/ready interface to the AES input buffer.
- Flags framing errors and overruns.

Parameters:
N_DATA_BITS, 8, data bits per frame (≥5)
OVERSAMPLE, 16, i_uart_en ticks per bit period (even, ≥4)

Ports:
i_uart_clk  input  1  system clock
i_uart_reset  input  1  reset, synchronous, active-low
i_uart_en  input  1  oversample tick, OVERSAMPLE × baud rate
i_uart_rx  input  1  asynchronous serial line, idles high
i_uart_ready  input  1  consumer can accept o_uart_data
o_uart_data  output  N_DATA_BITS  received word
o_uart_data_valid  output  1  o_uart_data holds an unconsumed word
o_uart_frame_err  output  1  one-clock pulse: stop bit sampled low
o_uart_overrun  output  1  one-clock pulse: good frame dropped, buffer full
o_uart_busy  output  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock, i_uart_clk. Reset is synchronous, active-low (i_uart_reset=0). It acts on any edge regardless of i_uart_en and has priority over everything else.
- Reset values:
  - o_uart_data=0, o_uart_data_valid=0, o_uart_frame_err=0, o_uart_overrun=0, o_uart_busy=0.
  - State=IDLE; tick_cnt, bit_idx and shift register=0; both synchronizer flops=1.
- Synchronizer: 2-flop on i_uart_rx, clocked every cycle (not gated by en). rx_s is the second flop.
- Gating: FSM counters and samples advance only on edges with i_uart_en=1. Output handshake logic runs every clock.
- FSM:
  - IDLE: on en && rx_s==0 → START, tick_cnt=0.
  - START: tick_cnt increments per tick. When tick_cnt==OVERSAMPLE/2-1, sample rx_s:
    - 0 → DATA, tick_cnt=0, bit_idx=0.
    - 1 → IDLE. This is glitch rejection: no output, no error.
  - DATA: when tick_cnt==OVERSAMPLE-1, shift reg[bit_idx]=rx_s and tick_cnt=0. After bit_idx==N_DATA_BITS-1 → STOP, else bit_idx+1.
  - STOP: when tick_cnt==OVERSAMPLE-1, sample rx_s:
    - 1 → deliver, → IDLE.
    - 0 → o_uart_frame_err=1 for that clock, word discarded, → BREAK.
  - BREAK: stay until en && rx_s==1, then → IDLE. Prevents a held-low line from retriggering.
- Timing: the stop sample occurs OVERSAMPLE/2 + (N_DATA_BITS+1)·OVERSAMPLE ticks after the IDLE detect tick. With defaults that is 152 ticks.
- Delivery on the stop-sample edge:
  - If !valid, or valid && i_uart_ready on the same edge: load o_uart_data and set valid=1.
  - Else (valid && !ready): keep the old word unchanged and pulse o_uart_overrun=1 for one clock.
- Handshake:
  - Transfer occurs on an edge with valid && i_uart_ready; valid clears unless a new load happens on that edge.
  - o_uart_data is stable while valid=1. Ready may be high with valid=0 (no effect).
- o_uart_busy = (state != IDLE), registered with the state.
- Reset mid-frame: the partial frame is lost and no error is flagged.

Decomposition:
- Shared uart_pkg (include) holds:
  - FSM state encodings: IDLE, START, DATA, STOP, BREAK.
  - Defaults for N_DATA_BITS and OVERSAMPLE, shared with uart_tx.
  - Counter widths: $clog2(OVERSAMPLE), $clog2(N_DATA_BITS).
- One sub-module: uart_rx_sync, a 2-flop synchronizer with reset value 1, reusable by other async inputs.

Test Plan:
1. Reset, en every clock, ready=1, frame 0xA5 at 16 ticks/bit → valid rises 152 ticks after start detect plus 1 clock, data=0xA5, valid drops the next clock, no error pulses.
2. rx low for 4 ticks, then high → no valid, no frame_err, busy returns to 0 at tick 8.
3. Frame 0x3C with stop bit=0 → frame_err pulses 1 clock, valid stays 0. Hold line low 40 ticks, then high, then send 0x81 → data=0x81 valid, busy held 1 through the low period.
4. ready=0, frames 0x11 then 0x22 → data stays 0x11, overrun pulses at the second stop sample. Raise ready → 0x11 consumed, valid=0.
5. Consumer asserts ready on exactly the stop-sample edge of the next frame (0x33 then 0x44) → 0x33 transferred, 0x44 loaded, valid stays 1 continuously, no overrun.
6. en every 3rd clock, frame 0x5A; assert reset at data bit 3 of a second frame → first frame gives data=0x5A. Reset returns all outputs to reset values next clock; a following 0xC3 frame is received correctly.
